// File: rtl/fsab_initiator_pkg.sv
// Purpose: shared FSAB bus widths, encodings and initiator state/type definitions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fsab_initiator_pkg;

  localparam int FSAB_REQ_HI     = 0;
  localparam int FSAB_DID_HI     = 4;
  localparam int FSAB_ADDR_HI    = 30;
  localparam int FSAB_LEN_HI     = 3;
  localparam int FSAB_DATA_HI    = 63;
  localparam int FSAB_MASK_HI    = 7;
  localparam int FSAB_CREDITS_HI = 2;
  localparam int FSAB_LEN_MAX    = 8;

  localparam logic [FSAB_CREDITS_HI:0] FSAB_INITIAL_CREDITS = 3'd4;

  localparam logic [FSAB_REQ_HI:0] FSAB_READ  = 1'b0;
  localparam logic [FSAB_REQ_HI:0] FSAB_WRITE = 1'b1;

  // Initiator FSM encodings
  typedef enum logic {
    FSAB_INIT_IDLE   = 1'b0,
    FSAB_INIT_WBURST = 1'b1
  } fsab_init_state_e;

  // One write-FIFO entry: word plus its byte enables
  typedef struct packed {
    logic [FSAB_DATA_HI:0] data;
    logic [FSAB_MASK_HI:0] mask;
  } fsab_wword_t;

endpackage

// File: rtl/fsab_initiator_if.sv
// Purpose: client request/write/read-return and FSAB bus signals of one initiator.
// Latency: n/a (wiring only).
// Backpressure: req_ready/wr_ready toward the client, fsabo_credit from the bus.
interface fsab_initiator_if;
  import fsab_initiator_pkg::*;

  logic                          req_valid;
  logic                          req_ready;
  logic [FSAB_REQ_HI:0]          req_mode;
  logic [FSAB_DID_HI:0]          req_subdid;
  logic [FSAB_ADDR_HI:0]         req_addr;
  logic [FSAB_LEN_HI:0]          req_len;

  logic                          wr_valid;
  logic                          wr_ready;
  logic [FSAB_DATA_HI:0]         wr_data;
  logic [FSAB_MASK_HI:0]         wr_mask;

  logic                          fsabo_valid;
  logic [FSAB_REQ_HI:0]          fsabo_mode;
  logic [FSAB_DID_HI:0]          fsabo_did;
  logic [FSAB_DID_HI:0]          fsabo_subdid;
  logic [FSAB_ADDR_HI:0]         fsabo_addr;
  logic [FSAB_LEN_HI:0]          fsabo_len;
  logic [FSAB_DATA_HI:0]         fsabo_data;
  logic [FSAB_MASK_HI:0]         fsabo_mask;
  logic                          fsabo_credit;

  logic                          fsabi_valid;
  logic [FSAB_DID_HI:0]          fsabi_did;
  logic [FSAB_DID_HI:0]          fsabi_subdid;
  logic [FSAB_DATA_HI:0]         fsabi_data;

  logic                          rd_valid;
  logic [FSAB_DID_HI:0]          rd_subdid;
  logic [FSAB_DATA_HI:0]         rd_data;
  logic [FSAB_CREDITS_HI+FSAB_LEN_HI+1:0] rd_outstanding;
  logic [FSAB_CREDITS_HI:0]      credits;

  // Initiator side
  modport master (
    input  req_valid, req_mode, req_subdid, req_addr, req_len,
    input  wr_valid, wr_data, wr_mask,
    input  fsabo_credit,
    input  fsabi_valid, fsabi_did, fsabi_subdid, fsabi_data,
    output req_ready, wr_ready,
    output fsabo_valid, fsabo_mode, fsabo_did, fsabo_subdid, fsabo_addr,
    output fsabo_len, fsabo_data, fsabo_mask,
    output rd_valid, rd_subdid, rd_data, rd_outstanding, credits
  );

  // Client plus bus-partner side
  modport slave (
    output req_valid, req_mode, req_subdid, req_addr, req_len,
    output wr_valid, wr_data, wr_mask,
    output fsabo_credit,
    output fsabi_valid, fsabi_did, fsabi_subdid, fsabi_data,
    input  req_ready, wr_ready,
    input  fsabo_valid, fsabo_mode, fsabo_did, fsabo_subdid, fsabo_addr,
    input  fsabo_len, fsabo_data, fsabo_mask,
    input  rd_valid, rd_subdid, rd_data, rd_outstanding, credits
  );

endinterface

// File: rtl/fsab_init_wfifo.sv
// Purpose: synchronous write-data FIFO of {data, mask} with occupancy count.
// Latency: pushed word visible at the head one cycle after the push.
// Backpressure: full_o blocks pushes; pops on an empty FIFO are ignored.
module fsab_init_wfifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 72,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && (count_q != '0);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/fsab_initiator.sv
// Purpose: FSAB master port: client requests to fsabo beats, credit tracking, DID-filtered read return.
// Latency: first bus beat one cycle after req handshake; read word one cycle after matching fsabi beat.
// Backpressure: req_ready needs IDLE, a credit and (for writes) len words buffered; wr_ready = !full; rd_* has none.
module fsab_initiator
  import fsab_initiator_pkg::*;
#(
  parameter logic [FSAB_DID_HI:0] DID = '0,
  parameter int WFIFO_DEPTH           = FSAB_LEN_MAX
) (
  input  logic             clk,
  input  logic             rst_b,
  fsab_initiator_if.master bus
);

  localparam int CW = $clog2(WFIFO_DEPTH) + 1;
  localparam int OW = FSAB_CREDITS_HI + FSAB_LEN_HI + 2;
  localparam logic [FSAB_LEN_HI:0] LEN_ONE = 1;

  fsab_init_state_e          state_q, state_d;
  logic [FSAB_LEN_HI:0]      beats_rem_q, beats_rem_d;
  logic [FSAB_CREDITS_HI:0]  credits_q, credits_d;
  logic [OW-1:0]             rd_out_q, rd_out_d;

  logic                      fsabo_valid_q, fsabo_valid_d;
  logic [FSAB_REQ_HI:0]      fsabo_mode_q, fsabo_mode_d;
  logic [FSAB_DID_HI:0]      fsabo_did_q, fsabo_did_d;
  logic [FSAB_DID_HI:0]      fsabo_subdid_q, fsabo_subdid_d;
  logic [FSAB_ADDR_HI:0]     fsabo_addr_q, fsabo_addr_d;
  logic [FSAB_LEN_HI:0]      fsabo_len_q, fsabo_len_d;
  logic [FSAB_DATA_HI:0]     fsabo_data_q, fsabo_data_d;
  logic [FSAB_MASK_HI:0]     fsabo_mask_q, fsabo_mask_d;

  logic                      rd_valid_q;
  logic [FSAB_DID_HI:0]      rd_subdid_q;
  logic [FSAB_DATA_HI:0]     rd_data_q;

  logic                      req_hs, rd_issue, rd_accept, fifo_pop, fifo_full;
  logic [CW-1:0]             fifo_count;
  fsab_wword_t               fifo_head, fifo_din;

  assign fifo_din = {bus.wr_data, bus.wr_mask};

  fsab_init_wfifo #(
    .DEPTH (WFIFO_DEPTH),
    .WIDTH ($bits(fsab_wword_t))
  ) u_wfifo (
    .clk     (clk),
    .rst_b   (rst_b),
    .push_i  (bus.wr_valid),
    .pop_i   (fifo_pop),
    .din_i   (fifo_din),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  // Beats are registered, so the cycle the last write beat is on the bus is
  // already IDLE: accepting there gives back-to-back beats with no bubble.
  assign bus.req_ready = (state_q == FSAB_INIT_IDLE) && (credits_q != '0) &&
                         ((bus.req_mode == FSAB_READ) ||
                          (32'(fifo_count) >= 32'(bus.req_len)));
  assign req_hs    = bus.req_valid && bus.req_ready;
  assign rd_issue  = req_hs && (bus.req_mode == FSAB_READ);
  assign rd_accept = bus.fsabi_valid && (bus.fsabi_did == DID);
  assign bus.wr_ready = !fifo_full;

  // Burst FSM: pick the next bus beat and the FIFO pop
  always_comb begin
    state_d        = state_q;
    beats_rem_d    = beats_rem_q;
    fifo_pop       = 1'b0;
    fsabo_valid_d  = 1'b0;
    fsabo_mode_d   = fsabo_mode_q;
    fsabo_did_d    = fsabo_did_q;
    fsabo_subdid_d = fsabo_subdid_q;
    fsabo_addr_d   = fsabo_addr_q;
    fsabo_len_d    = fsabo_len_q;
    fsabo_data_d   = fsabo_data_q;
    fsabo_mask_d   = fsabo_mask_q;
    case (state_q)
      FSAB_INIT_IDLE: begin
        if (req_hs) begin
          fsabo_valid_d  = 1'b1;
          fsabo_mode_d   = bus.req_mode;
          fsabo_did_d    = DID;
          fsabo_subdid_d = bus.req_subdid;
          fsabo_addr_d   = bus.req_addr;
          fsabo_len_d    = bus.req_len;
          if (bus.req_mode == FSAB_WRITE) begin
            fifo_pop     = 1'b1;
            fsabo_data_d = fifo_head.data;
            fsabo_mask_d = fifo_head.mask;
            if (bus.req_len > LEN_ONE) begin
              state_d     = FSAB_INIT_WBURST;
              beats_rem_d = bus.req_len - 1'b1;
            end
          end else begin
            fsabo_data_d = '0;
            fsabo_mask_d = '0;
          end
        end
      end
      FSAB_INIT_WBURST: begin
        fsabo_valid_d = 1'b1;
        fifo_pop      = 1'b1;
        fsabo_data_d  = fifo_head.data;
        fsabo_mask_d  = fifo_head.mask;
        beats_rem_d   = beats_rem_q - 1'b1;
        if (beats_rem_q == LEN_ONE) state_d = FSAB_INIT_IDLE;
      end
      default: state_d = FSAB_INIT_IDLE;
    endcase
  end

  // Credit and outstanding-read bookkeeping
  always_comb begin
    credits_d = credits_q;
    case ({req_hs, bus.fsabo_credit})
      2'b10:   credits_d = credits_q - 1'b1;
      2'b01:   credits_d = credits_q + 1'b1;
      default: credits_d = credits_q;
    endcase
    rd_out_d = rd_out_q + (rd_issue ? OW'(bus.req_len) : OW'(0)) - OW'(rd_accept);
  end

  // State, bus beat and read-return registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q        <= FSAB_INIT_IDLE;
      beats_rem_q    <= '0;
      credits_q      <= FSAB_INITIAL_CREDITS;
      rd_out_q       <= '0;
      fsabo_valid_q  <= 1'b0;
      fsabo_mode_q   <= '0;
      fsabo_did_q    <= '0;
      fsabo_subdid_q <= '0;
      fsabo_addr_q   <= '0;
      fsabo_len_q    <= '0;
      fsabo_data_q   <= '0;
      fsabo_mask_q   <= '0;
      rd_valid_q     <= 1'b0;
      rd_subdid_q    <= '0;
      rd_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      beats_rem_q    <= beats_rem_d;
      credits_q      <= credits_d;
      rd_out_q       <= rd_out_d;
      fsabo_valid_q  <= fsabo_valid_d;
      fsabo_mode_q   <= fsabo_mode_d;
      fsabo_did_q    <= fsabo_did_d;
      fsabo_subdid_q <= fsabo_subdid_d;
      fsabo_addr_q   <= fsabo_addr_d;
      fsabo_len_q    <= fsabo_len_d;
      fsabo_data_q   <= fsabo_data_d;
      fsabo_mask_q   <= fsabo_mask_d;
      rd_valid_q     <= rd_accept;
      if (rd_accept) begin
        rd_subdid_q <= bus.fsabi_subdid;
        rd_data_q   <= bus.fsabi_data;
      end
    end
  end

  assign bus.fsabo_valid    = fsabo_valid_q;
  assign bus.fsabo_mode     = fsabo_mode_q;
  assign bus.fsabo_did      = fsabo_did_q;
  assign bus.fsabo_subdid   = fsabo_subdid_q;
  assign bus.fsabo_addr     = fsabo_addr_q;
  assign bus.fsabo_len      = fsabo_len_q;
  assign bus.fsabo_data     = fsabo_data_q;
  assign bus.fsabo_mask     = fsabo_mask_q;
  assign bus.rd_valid       = rd_valid_q;
  assign bus.rd_subdid      = rd_subdid_q;
  assign bus.rd_data        = rd_data_q;
  assign bus.rd_outstanding = rd_out_q;
  assign bus.credits        = credits_q;

  a_req_len: assert property (@(posedge clk) disable iff (!rst_b)
    req_hs |-> (bus.req_len != '0) && (32'(bus.req_len) <= FSAB_LEN_MAX));
  a_wr_full: assert property (@(posedge clk) disable iff (!rst_b)
    bus.wr_valid |-> !fifo_full);
  a_credit_ovf: assert property (@(posedge clk) disable iff (!rst_b)
    (bus.fsabo_credit && !req_hs) |-> (credits_q != FSAB_INITIAL_CREDITS));
  a_rd_underflow: assert property (@(posedge clk) disable iff (!rst_b)
    (rd_accept && !rd_issue) |-> (rd_out_q != '0));

endmodule

// File: tb/tb_fsab_initiator.sv
module tb_fsab_initiator;
  import fsab_initiator_pkg::*;

  localparam logic [FSAB_DID_HI:0] TB_DID = 5'd2;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic                  hdr;
    logic [FSAB_REQ_HI:0]  mode;
    logic [FSAB_DID_HI:0]  subdid;
    logic [FSAB_ADDR_HI:0] addr;
    logic [FSAB_LEN_HI:0]  len;
    logic [FSAB_DATA_HI:0] data;
    logic [FSAB_MASK_HI:0] mask;
  } beat_t;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fsab_initiator_if bus ();

  fsab_initiator #(.DID(TB_DID), .WFIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_cur: beat expected on the bus this cycle; m_pend: later beats of the burst
  logic                  m_cur_vld;
  beat_t                 m_cur;
  beat_t                 m_pend[$];
  logic [71:0]           m_fifo[$];
  int                    m_credits;
  int                    m_rd_out;
  logic                  m_rd_vld;
  logic [FSAB_DID_HI:0]  m_rd_sub;
  logic [FSAB_DATA_HI:0] m_rd_dat;

  task automatic model_reset();
    m_cur_vld = 1'b0;
    m_cur     = '0;
    m_pend.delete();
    m_fifo.delete();
    m_credits = int'(FSAB_INITIAL_CREDITS);
    m_rd_out  = 0;
    m_rd_vld  = 1'b0;
    m_rd_sub  = '0;
    m_rd_dat  = '0;
  endtask

  initial model_reset();

  always @(negedge clk) begin : cmp
    int    occ;
    logic  exp_rdy, hs, acc;
    beat_t b;
    logic [71:0] w;
    if (!rst_b) begin
      chk("rst_fsabo_valid", 64'(bus.fsabo_valid), 64'd0);
      chk("rst_credits", 64'(bus.credits), 64'(FSAB_INITIAL_CREDITS));
      chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
      chk("rst_rd_outstanding", 64'(bus.rd_outstanding), 64'd0);
      chk("rst_wr_ready", 64'(bus.wr_ready), 64'd1);
      model_reset();
    end else begin
      occ = m_fifo.size() + m_pend.size();
      exp_rdy = (m_pend.size() == 0) && (m_credits != 0) &&
                ((bus.req_mode == FSAB_READ) || (m_fifo.size() >= int'(bus.req_len)));
      chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      chk("wr_ready", 64'(bus.wr_ready), 64'(occ < DEPTH));
      chk("credits", 64'(bus.credits), 64'(m_credits));
      chk("rd_outstanding", 64'(bus.rd_outstanding), 64'(m_rd_out));
      chk("fsabo_valid", 64'(bus.fsabo_valid), 64'(m_cur_vld));
      if (m_cur_vld) begin
        chk("fsabo_data", bus.fsabo_data, m_cur.data);
        chk("fsabo_mask", 64'(bus.fsabo_mask), 64'(m_cur.mask));
        if (m_cur.hdr) begin
          chk("fsabo_mode", 64'(bus.fsabo_mode), 64'(m_cur.mode));
          chk("fsabo_did", 64'(bus.fsabo_did), 64'(TB_DID));
          chk("fsabo_subdid", 64'(bus.fsabo_subdid), 64'(m_cur.subdid));
          chk("fsabo_addr", 64'(bus.fsabo_addr), 64'(m_cur.addr));
          chk("fsabo_len", 64'(bus.fsabo_len), 64'(m_cur.len));
        end
      end
      chk("rd_valid", 64'(bus.rd_valid), 64'(m_rd_vld));
      if (m_rd_vld) begin
        chk("rd_data", bus.rd_data, m_rd_dat);
        chk("rd_subdid", 64'(bus.rd_subdid), 64'(m_rd_sub));
      end

      // advance the model across the coming clock edge
      hs  = bus.req_valid && exp_rdy;
      acc = bus.fsabi_valid && (bus.fsabi_did == TB_DID);
      m_cur_vld = 1'b0;
      if (m_pend.size() != 0) begin
        m_cur = m_pend.pop_front();
        m_cur_vld = 1'b1;
      end
      if (hs) begin
        for (int i = 0; i < int'(bus.req_len); i++) begin
          b = '0;
          b.hdr = (i == 0);
          b.mode = bus.req_mode;
          b.subdid = bus.req_subdid;
          b.addr = bus.req_addr;
          b.len = bus.req_len;
          if (bus.req_mode == FSAB_WRITE) begin
            w = m_fifo.pop_front();
            b.data = w[71:8];
            b.mask = w[7:0];
          end
          if (i == 0) begin
            m_cur = b;
            m_cur_vld = 1'b1;
          end else begin
            m_pend.push_back(b);
          end
          if (bus.req_mode == FSAB_READ) break;
        end
        if (bus.req_mode == FSAB_READ) m_rd_out += int'(bus.req_len);
      end
      if (bus.wr_valid && (occ < DEPTH)) m_fifo.push_back({bus.wr_data, bus.wr_mask});
      m_credits = m_credits - int'(hs) + int'(bus.fsabo_credit);
      m_rd_vld = acc;
      if (acc) begin
        m_rd_sub = bus.fsabi_subdid;
        m_rd_dat = bus.fsabi_data;
        m_rd_out -= 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [63:0] d, input logic [7:0] m);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    bus.wr_mask  = m;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic pulse_credit();
    bus.fsabo_credit = 1'b1;
    tick();
    bus.fsabo_credit = 1'b0;
  endtask

  // Returns at handshake edge + 1; n is the number of extra cycles waited
  task automatic do_req(input logic [FSAB_REQ_HI:0] mode, input logic [FSAB_DID_HI:0] sub,
                        input logic [FSAB_ADDR_HI:0] addr, input logic [FSAB_LEN_HI:0] len,
                        output int n);
    n = 0;
    bus.req_valid  = 1'b1;
    bus.req_mode   = mode;
    bus.req_subdid = sub;
    bus.req_addr   = addr;
    bus.req_len    = len;
    @(negedge clk);
    while (!bus.req_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("req_timeout", 64'd1, 64'd0);
    tick();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int n;
    bus.req_valid = 0; bus.req_mode = FSAB_READ; bus.req_subdid = '0;
    bus.req_addr = '0; bus.req_len = '0;
    bus.wr_valid = 0; bus.wr_data = '0; bus.wr_mask = '0;
    bus.fsabo_credit = 0;
    bus.fsabi_valid = 0; bus.fsabi_did = '0; bus.fsabi_subdid = '0; bus.fsabi_data = '0;

    repeat (3) tick();
    rst_b = 1'b1;
    tick();
    chk("init_credits", 64'(bus.credits), 64'd4);

    // 4-word write to 0x100
    for (int i = 0; i < 4; i++) push_word(64'hA0 + 64'(i), 8'hFF);
    do_req(FSAB_WRITE, 5'd1, 31'h100, 4'd4, n);
    chk("w4_len", 64'(bus.fsabo_len), 64'd4);
    chk("w4_addr", 64'(bus.fsabo_addr), 64'h100);
    chk("w4_data0", bus.fsabo_data, 64'hA0);
    chk("w4_credits", 64'(bus.credits), 64'd3);
    repeat (3) tick();
    chk("w4_data3", bus.fsabo_data, 64'hA3);
    tick();
    chk("w4_done", 64'(bus.fsabo_valid), 64'd0);
    pulse_credit();
    chk("w4_credit_back", 64'(bus.credits), 64'd4);

    // read len 8 with interleaved foreign-DID returns
    do_req(FSAB_READ, 5'd3, 31'h200, 4'd8, n);
    chk("r8_data", bus.fsabo_data, 64'd0);
    chk("r8_len", 64'(bus.fsabo_len), 64'd8);
    chk("r8_outstanding", 64'(bus.rd_outstanding), 64'd8);
    for (int i = 0; i < 16; i++) begin
      bus.fsabi_valid  = 1'b1;
      bus.fsabi_did    = (i % 2 == 0) ? TB_DID : 5'd1;
      bus.fsabi_subdid = (i % 2 == 0) ? 5'd3 : 5'd7;
      bus.fsabi_data   = 64'hD00 + 64'(i);
      tick();
      if (i == 0) begin
        chk("r8_first_vld", 64'(bus.rd_valid), 64'd1);
        chk("r8_first_sub", 64'(bus.rd_subdid), 64'd3);
      end
      if (i == 1) chk("r8_foreign_ignored", 64'(bus.rd_valid), 64'd0);
    end
    bus.fsabi_valid = 1'b0;
    tick();
    chk("r8_outstanding_zero", 64'(bus.rd_outstanding), 64'd0);
    pulse_credit();

    // credit exhaustion
    for (int k = 0; k < 4; k++) do_req(FSAB_READ, 5'd4, 31'h300 + 31'(k * 8), 4'd1, n);
    chk("cr_zero", 64'(bus.credits), 64'd0);
    bus.req_valid = 1'b1;
    @(negedge clk);
    chk("cr_blocked", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    bus.fsabo_credit = 1'b1;
    tick();
    bus.fsabo_credit = 1'b1;   // coincides with the issue that follows
    @(negedge clk);
    chk("cr_ready_after_pulse", 64'(bus.req_ready), 64'd1);
    tick();
    bus.fsabo_credit = 1'b0;
    bus.req_valid = 1'b0;
    chk("cr_same_cycle", 64'(bus.credits), 64'd1);
    repeat (3) pulse_credit();
    chk("cr_full", 64'(bus.credits), 64'd4);

    // write len 4 with only 2 words buffered
    push_word(64'hE0, 8'h0F);
    push_word(64'hE1, 8'hF0);
    bus.req_valid = 1'b1; bus.req_mode = FSAB_WRITE; bus.req_subdid = 5'd5;
    bus.req_addr = 31'h400; bus.req_len = 4'd4;
    @(negedge clk);
    chk("short_ready2", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    push_word(64'hE2, 8'h3C);
    @(negedge clk);
    chk("short_ready3", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    push_word(64'hE3, 8'hC3);
    @(negedge clk);
    chk("short_ready4", 64'(bus.req_ready), 64'd1);
    tick();
    bus.req_valid = 1'b0;
    repeat (4) tick();

    // back-to-back write(2) + read
    push_word(64'hF0, 8'hFF);
    push_word(64'hF1, 8'hFF);
    do_req(FSAB_WRITE, 5'd6, 31'h500, 4'd2, n);
    do_req(FSAB_READ, 5'd6, 31'h508, 4'd1, n);
    chk("b2b_wait", 64'(n), 64'd1);
    chk("b2b_rd_valid", 64'(bus.fsabo_valid), 64'd1);
    chk("b2b_rd_mode", 64'(bus.fsabo_mode), 64'(FSAB_READ));
    tick();
    repeat (3) pulse_credit();

    // reset in the middle of a 4-beat write
    for (int i = 0; i < 4; i++) push_word(64'hC0 + 64'(i), 8'hFF);
    do_req(FSAB_WRITE, 5'd8, 31'h600, 4'd4, n);
    tick();
    chk("mid_beat2", bus.fsabo_data, 64'hC1);
    #1 rst_b = 1'b0;
    #1 chk("async_rst_valid", 64'(bus.fsabo_valid), 64'd0);
    tick();
    tick();
    rst_b = 1'b1;
    tick();
    chk("post_rst_credits", 64'(bus.credits), 64'd4);
    chk("post_rst_wr_ready", 64'(bus.wr_ready), 64'd1);
    push_word(64'h55, 8'h01);
    do_req(FSAB_WRITE, 5'd9, 31'h700, 4'd1, n);
    chk("post_rst_fifo_fresh", bus.fsabo_data, 64'h55);
    tick();
    pulse_credit();
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
